// File: rtl/fetch_ctrl_if.sv
// Bundle of PC, instruction-memory and execute-unit handshake signals seen by fetch_ctrl.
// master = fetch sequencer side, slave = PC / memory / execute side.
interface fetch_ctrl_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] pc_q;
  logic          pc_inc;
  logic          pc_ld;
  logic [AW-1:0] pc_ld_val;
  logic          mem_cs;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          exec_done;
  logic          br_taken;
  logic [AW-1:0] br_target;

  modport master (
    input  pc_q, mem_data, exec_done, br_taken, br_target,
    output pc_inc, pc_ld, pc_ld_val, mem_cs, mem_rd, mem_addr
  );

  modport slave (
    output pc_q, mem_data, exec_done, br_taken, br_target,
    input  pc_inc, pc_ld, pc_ld_val, mem_cs, mem_rd, mem_addr
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: FETCH/WAIT/DECODE/EXEC/HALT around a 16-bit PC block.
// Optional interrupt entry and RETI decode are built when FETCH_IRQ_EN is defined.
module fetch_ctrl #(
  parameter int            AW      = 16,
  parameter int            DW      = 16,
  parameter int            MEM_LAT = 2
`ifdef FETCH_IRQ_EN
  ,
  parameter logic [AW-1:0] IRQ_VEC = 16'h0100
`endif
) (
  input  logic          clk,
  input  logic          re,
  input  logic          i_start,
  fetch_ctrl_if.master  bus,
  output logic [DW-1:0] o_ir,
  output logic          o_ir_valid,
  output logic          o_halted,
  output logic [2:0]    o_state,
  output logic [15:0]   o_instr_cnt
`ifdef FETCH_IRQ_EN
  ,
  input  logic          i_irq,
  output logic          o_irq_ack,
  output logic [AW-1:0] o_epc
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [3:0] OP_JMP  = 4'hE;
`ifdef FETCH_IRQ_EN
  localparam logic [3:0] OP_RETI = 4'hD;
`endif
  localparam logic [3:0] LAT     = 4'(MEM_LAT);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [3:0]    r_wait;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_ir;
  logic [15:0]   r_cnt;
  logic [3:0]    w_opcode;
  logic          w_upd;
  logic          w_upd_ld;
  logic [AW-1:0] w_upd_val;
  logic          w_cnt_inc;
  logic          w_pc_inc;
  logic          w_pc_ld;
  logic [AW-1:0] w_pc_ld_val;
  logic [AW-1:0] w_mem_addr;
`ifdef FETCH_IRQ_EN
  logic          r_irq_en;
  logic [AW-1:0] r_epc;
  logic [AW-1:0] w_epc_nxt;
  logic          w_reti;
  logic          w_irq_take;
`endif

  assign w_opcode = r_ir[DW-1:DW-4];

  // w_upd marks a PC-update point; w_upd_ld/w_upd_val say whether it loads or increments
  always_comb begin
    w_next    = r_state;
    w_upd     = 1'b0;
    w_upd_ld  = 1'b0;
    w_upd_val = '0;
    w_cnt_inc = 1'b0;
`ifdef FETCH_IRQ_EN
    w_reti    = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_FETCH;
        else         w_next = S_IDLE;
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT: begin
        if (r_wait == 4'd1) w_next = S_DECODE;
        else                w_next = S_WAIT;
      end
      S_DECODE: begin
        case (w_opcode)
          OP_HALT: begin
            w_next    = S_HALT;
            w_cnt_inc = 1'b1;
          end
          OP_JMP: begin
            w_next    = S_FETCH;
            w_cnt_inc = 1'b1;
            w_upd     = 1'b1;
            w_upd_ld  = 1'b1;
            w_upd_val = AW'(r_ir[11:0]);
          end
`ifdef FETCH_IRQ_EN
          OP_RETI: begin
            w_next    = S_FETCH;
            w_cnt_inc = 1'b1;
            w_reti    = 1'b1;
          end
`endif
          default: w_next = S_EXEC;
        endcase
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          w_next    = S_FETCH;
          w_cnt_inc = 1'b1;
          w_upd     = 1'b1;
          w_upd_ld  = bus.br_taken;
          w_upd_val = bus.br_taken ? bus.br_target : '0;
        end else begin
          w_next    = S_EXEC;
        end
      end
      S_HALT: begin
        if (i_start) begin
          w_next = S_FETCH;
          w_upd  = 1'b1;
        end else begin
          w_next = S_HALT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // PC strobes; an accepted interrupt replaces the normal update with a load of the vector
  always_comb begin
    w_pc_inc    = 1'b0;
    w_pc_ld     = 1'b0;
    w_pc_ld_val = '0;
`ifdef FETCH_IRQ_EN
    w_irq_take  = 1'b0;
    w_epc_nxt   = w_upd_ld ? w_upd_val : bus.pc_q + AW'(1);
    if (w_upd && i_irq && r_irq_en) begin
      w_irq_take  = 1'b1;
      w_pc_ld     = 1'b1;
      w_pc_ld_val = IRQ_VEC;
    end else if (w_upd) begin
      w_pc_inc    = ~w_upd_ld;
      w_pc_ld     = w_upd_ld;
      w_pc_ld_val = w_upd_val;
    end else if (w_reti) begin
      w_pc_ld     = 1'b1;
      w_pc_ld_val = r_epc;
    end else begin
      w_irq_take  = 1'b0;
    end
`else
    if (w_upd) begin
      w_pc_inc    = ~w_upd_ld;
      w_pc_ld     = w_upd_ld;
      w_pc_ld_val = w_upd_val;
    end else begin
      w_pc_ld     = 1'b0;
    end
`endif
  end

  // FETCH presents the live PC; WAIT holds the copy latched at the end of FETCH
  always_comb begin
    case (r_state)
      S_FETCH: w_mem_addr = bus.pc_q;
      S_WAIT:  w_mem_addr = r_addr;
      default: w_mem_addr = '0;
    endcase
  end

  // State, wait counter, address hold, IR and retired count
  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      r_state <= S_IDLE;
      r_wait  <= 4'd0;
      r_addr  <= '0;
      r_ir    <= '0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH) begin
        r_wait <= LAT;
        r_addr <= bus.pc_q;
      end else if (r_state == S_WAIT) begin
        r_wait <= r_wait - 4'd1;
      end else begin
        r_wait <= r_wait;
      end
      if ((r_state == S_WAIT) && (r_wait == 4'd1)) r_ir <= bus.mem_data;
      if (w_cnt_inc) r_cnt <= r_cnt + 16'd1;
    end
  end

`ifdef FETCH_IRQ_EN
  // Interrupt enable and saved return address
  always_ff @(posedge clk or posedge re) begin
    if (re) begin
      r_irq_en <= 1'b1;
      r_epc    <= '0;
    end else if (w_irq_take) begin
      r_irq_en <= 1'b0;
      r_epc    <= w_epc_nxt;
    end else if (w_reti) begin
      r_irq_en <= 1'b1;
    end
  end

  assign o_irq_ack = w_irq_take;
  assign o_epc     = r_epc;
`endif

  assign bus.pc_inc    = w_pc_inc;
  assign bus.pc_ld     = w_pc_ld;
  assign bus.pc_ld_val = w_pc_ld_val;
  assign bus.mem_cs    = (r_state == S_FETCH) || (r_state == S_WAIT);
  assign bus.mem_rd    = (r_state == S_FETCH) || (r_state == S_WAIT);
  assign bus.mem_addr  = w_mem_addr;
  assign o_ir          = r_ir;
  assign o_ir_valid    = (r_state == S_DECODE);
  assign o_halted      = (r_state == S_HALT);
  assign o_state       = r_state;
  assign o_instr_cnt   = r_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an instruction-level reference model checked every cycle.
module tb_fetch_ctrl;
  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        re;
  logic        start;
  logic [15:0] ir;
  logic        ir_valid;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] instr_cnt;
`ifdef FETCH_IRQ_EN
  logic        irq;
  logic        irq_ack;
  logic [15:0] epc;
`endif

  fetch_ctrl_if #(.AW(16), .DW(16)) bus ();

  fetch_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk        (clk),
    .re         (re),
    .i_start    (start),
    .bus        (bus),
    .o_ir       (ir),
    .o_ir_valid (ir_valid),
    .o_halted   (halted),
    .o_state    (state),
    .o_instr_cnt(instr_cnt)
`ifdef FETCH_IRQ_EN
    ,
    .i_irq      (irq),
    .o_irq_ack  (irq_ack),
    .o_epc      (epc)
`endif
  );

  always #5 clk = ~clk;

  // Environment: program memory and PC register driven by the DUT strobes
  logic [15:0] mem [0:4095];
  logic [15:0] tb_pc;
  logic        pc_force;
  logic [15:0] pc_force_val;

  assign bus.mem_data = mem[bus.mem_addr[11:0]];
  assign bus.pc_q     = tb_pc;

  always @(posedge clk) begin
    if (pc_force)        tb_pc <= pc_force_val;
    else if (bus.pc_ld)  tb_pc <= bus.pc_ld_val;
    else if (bus.pc_inc) tb_pc <= tb_pc + 16'd1;
  end

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: program-level view (expected PC, retired count, pending exec, halted)
  logic [15:0] m_pc, m_cnt, want, exp_val, upd_val;
  logic        m_idle, m_halted, m_in_exec;
  logic        exp_inc, exp_ld, exp_ack, upd, upd_ld;
  logic [3:0]  op;
  int          burst = 0;
  int          last_burst = 0;
`ifdef FETCH_IRQ_EN
  logic [15:0] m_epc;
  logic        m_irq_en;
`endif

  initial forever begin
    @(negedge clk);
    if (re) begin
      check("rst_bus", 64'({bus.pc_inc, bus.pc_ld, bus.pc_ld_val, bus.mem_cs, bus.mem_rd, bus.mem_addr}), 64'd0);
      check("rst_core", 64'({ir, ir_valid, halted, state, instr_cnt}), 64'd0);
      m_cnt = 16'd0; m_idle = 1'b1; m_halted = 1'b0; m_in_exec = 1'b0; burst = 0;
`ifdef FETCH_IRQ_EN
      m_epc = 16'd0; m_irq_en = 1'b1;
`endif
    end else begin
      check("instr_cnt", 64'(instr_cnt), 64'(m_cnt));
      check("halted", 64'(halted), 64'(m_halted));
      check("idle", 64'(state == 3'd0), 64'(m_idle));
      check("in_exec", 64'(state == 3'd4), 64'(m_in_exec));
      check("cs_eq_rd", 64'(bus.mem_rd), 64'(bus.mem_cs));
`ifdef FETCH_IRQ_EN
      check("epc", 64'(epc), 64'(m_epc));
`endif
      if (bus.mem_cs) begin
        check("mem_addr", 64'(bus.mem_addr), 64'(m_pc));
        burst++;
      end else if (burst != 0) begin
        check("burst_len", 64'(burst), 64'(1 + MEM_LAT));
        last_burst = burst;
        burst = 0;
      end
      exp_inc = 1'b0; exp_ld = 1'b0; exp_val = 16'd0; exp_ack = 1'b0;
      upd = 1'b0; upd_ld = 1'b0; upd_val = 16'd0;
      if (m_idle && start) begin
        m_idle = 1'b0;
        m_pc   = tb_pc;
      end else if (ir_valid) begin
        want = mem[m_pc[11:0]];
        check("ir", 64'(ir), 64'(want));
        op = want[15:12];
        if (op == 4'hF) begin
          m_halted = 1'b1; m_cnt = m_cnt + 16'd1;
        end else if (op == 4'hE) begin
          upd = 1'b1; upd_ld = 1'b1; upd_val = {4'h0, want[11:0]}; m_cnt = m_cnt + 16'd1;
`ifdef FETCH_IRQ_EN
        end else if (op == 4'hD) begin
          exp_ld = 1'b1; exp_val = m_epc; m_pc = m_epc; m_irq_en = 1'b1; m_cnt = m_cnt + 16'd1;
`endif
        end else begin
          m_in_exec = 1'b1;
        end
      end else if (m_in_exec && bus.exec_done) begin
        upd = 1'b1; upd_ld = bus.br_taken; upd_val = bus.br_taken ? bus.br_target : 16'd0;
        m_in_exec = 1'b0; m_cnt = m_cnt + 16'd1;
      end else if (m_halted && start) begin
        upd = 1'b1; m_halted = 1'b0;
      end
      if (upd) begin
        want    = upd_ld ? upd_val : m_pc + 16'd1;
        exp_inc = ~upd_ld; exp_ld = upd_ld; exp_val = upd_val;
`ifdef FETCH_IRQ_EN
        if (irq && m_irq_en) begin
          exp_inc = 1'b0; exp_ld = 1'b1; exp_val = 16'h0100; exp_ack = 1'b1;
          m_epc = want; m_irq_en = 1'b0; want = 16'h0100;
        end
`endif
        m_pc = want;
      end
      check("pc_inc", 64'(bus.pc_inc), 64'(exp_inc));
      check("pc_ld", 64'(bus.pc_ld), 64'(exp_ld));
      if (exp_ld) check("pc_ld_val", 64'(bus.pc_ld_val), 64'(exp_val));
`ifdef FETCH_IRQ_EN
      check("irq_ack", 64'(irq_ack), 64'(exp_ack));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string nm);
    int n = 0;
    while (state !== s && n < 40) begin
      tick();
      n++;
    end
    check(nm, 64'(state), 64'(s));
  endtask

  task automatic go(input logic [15:0] pc0);
    pc_force = 1'b1; pc_force_val = pc0;
    tick();
    pc_force = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic begin_exec(input logic tk, input logic [15:0] tgt);
    wait_state(3'd4, "reach_exec");
    bus.exec_done = 1'b1; bus.br_taken = tk; bus.br_target = tgt;
    #1;
  endtask

  task automatic end_exec();
    tick();
    bus.exec_done = 1'b0; bus.br_taken = 1'b0; bus.br_target = 16'd0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    re = 1'b1; start = 1'b0; pc_force = 1'b1; pc_force_val = 16'd0;
    bus.exec_done = 1'b0; bus.br_taken = 1'b0; bus.br_target = 16'd0;
`ifdef FETCH_IRQ_EN
    irq = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[16'h000] = 16'h1234;  mem[16'h001] = 16'hE3E8;  mem[16'h3E8] = 16'h2000;
    mem[16'h040] = 16'hF000;  mem[16'h041] = 16'h3000;  mem[16'h042] = 16'h4000;
    mem[16'h050] = 16'hD123;  mem[16'h051] = 16'hF000;
    mem[16'h010] = 16'h5000;  mem[16'h011] = 16'hF000;  mem[16'h100] = 16'hD000;

    repeat (2) tick();
    re = 1'b0; pc_force = 1'b0;
    repeat (5) begin
      tick();
      check("idle_state", 64'(state), 64'(3'd0));
      check("idle_outs", 64'({bus.pc_inc, bus.pc_ld, bus.mem_cs, bus.mem_rd, bus.mem_addr, ir_valid, halted}), 64'd0);
      check("idle_cnt", 64'(instr_cnt), 64'd0);
    end

    go(16'h0000);
    check("fetch_cs", 64'({bus.mem_cs, bus.mem_rd}), 64'(2'b11));
    check("fetch_addr", 64'(bus.mem_addr), 64'h0);
    wait_state(3'd3, "reach_decode1");
    check("ir_1234", 64'(ir), 64'h1234);
    check("ir_valid", 64'(ir_valid), 64'd1);
    begin_exec(1'b0, 16'h0000);
    check("t2_inc", 64'({bus.pc_inc, bus.pc_ld}), 64'(2'b10));
    end_exec();
    check("t2_cnt", 64'(instr_cnt), 64'd1);
    check("t2_burst", 64'(last_burst), 64'd3);

    wait_state(3'd3, "reach_decode_jmp");
    check("jmp_ld", 64'({bus.pc_inc, bus.pc_ld}), 64'(2'b01));
    check("jmp_val", 64'(bus.pc_ld_val), 64'h03E8);
    tick();
    check("jmp_to_fetch", 64'(state), 64'(3'd1));
    check("jmp_cnt", 64'(instr_cnt), 64'd2);

    begin_exec(1'b1, 16'h0040);
    check("br_ld", 64'({bus.pc_inc, bus.pc_ld}), 64'(2'b01));
    check("br_val", 64'(bus.pc_ld_val), 64'h0040);
    end_exec();

    wait_state(3'd5, "reach_halt");
    repeat (3) begin
      check("halt_flag", 64'(halted), 64'd1);
      check("halt_no_mem", 64'(bus.mem_cs), 64'd0);
      tick();
    end
    check("halt_cnt", 64'(instr_cnt), 64'd4);
    start = 1'b1;
    #1;
    check("resume_inc", 64'({bus.pc_inc, bus.pc_ld}), 64'(2'b10));
    tick();
    start = 1'b0;
    check("resume_fetch", 64'(state), 64'(3'd1));

    begin_exec(1'b0, 16'h0000);
    end_exec();
    wait_state(3'd2, "reach_wait");
    #1;
    re = 1'b1;
    #1;
    check("async_rst_cs", 64'(bus.mem_cs), 64'd0);
    check("async_rst_state", 64'(state), 64'(3'd0));
    tick();
    re = 1'b0;

`ifndef FETCH_IRQ_EN
    go(16'h0050);
    begin_exec(1'b0, 16'h0000);
    end_exec();
    wait_state(3'd5, "d_op_halt");
    check("d_op_cnt", 64'(instr_cnt), 64'd2);
`else
    go(16'h0010);
    begin_exec(1'b0, 16'h0000);
    irq = 1'b1;
    #1;
    check("irq_vec", 64'(bus.pc_ld_val), 64'h0100);
    check("irq_ack_lit", 64'({irq_ack, bus.pc_inc, bus.pc_ld}), 64'(3'b101));
    end_exec();
    irq = 1'b0;
    check("epc_lit", 64'(epc), 64'h0011);
    wait_state(3'd3, "reti_decode");
    check("reti_val", 64'(bus.pc_ld_val), 64'h0011);
    wait_state(3'd5, "irq_halt");
`endif
    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
